// File: rtl/sayac_seq_divider.sv
// Multi-cycle unsigned restoring divider for the SAYAC datapath.
// One trial subtraction per cycle through a shared adder_subtractor, MSB first.

module adder_subtractor #(
   parameter int unsigned width = 17
) (
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   input  logic             subsel,
   output logic [width-1:0] sum,
   output logic             cout
);
   logic [width-1:0] b_eff;
   logic [width:0]   full;

   // Subtraction as a + ~b + 1; cout high means no borrow.
   always_comb begin
      b_eff = b ^ {width{subsel}};
      full  = {1'b0, a} + {1'b0, b_eff} + {{width{1'b0}}, subsel};
   end

   assign sum  = full[width-1:0];
   assign cout = full[width];
endmodule

// state  | meaning
// IDLE   | waiting for start; results held
// RUN    | one restoring step per cycle, size steps total
// DONE   | done pulse; results valid, always returns to IDLE
module sayac_seq_divider #(
   parameter int unsigned size = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [size-1:0] dividend,
   input  logic [size-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [size-1:0] quotient,
   output logic [size-1:0] remainder,
   output logic            div_by_zero
);
   localparam int unsigned     CW       = (size > 2) ? $clog2(size) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(size - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [size-1:0] q_q, q_d;
   logic [size-1:0] d_q, d_d;
   logic [size:0]   r_q, r_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            dbz_q, dbz_d;
   logic [size-1:0] quot_q, quot_d;
   logic [size-1:0] rem_q, rem_d;

   logic [size:0]   trial;
   logic [size:0]   diff;
   logic            no_borrow;
   logic            unused_r_msb;

   // Partial remainder never exceeds the divisor, so its top bit only feeds the trial width.
   assign trial        = {r_q[size-1:0], q_q[size-1]};
   assign unused_r_msb = r_q[size];

   adder_subtractor #(
      .width (size + 1)
   ) u_sub (
      .a      (trial),
      .b      ({1'b0, d_q}),
      .subsel (1'b1),
      .sum    (diff),
      .cout   (no_borrow)
   );

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      d_d     = d_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      quot_d  = quot_q;
      rem_d   = rem_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               q_d    = dividend;
               d_d    = divisor;
               r_d    = '0;
               cnt_d  = '0;
               busy_d = 1'b1;
               if (divisor == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  quot_d  = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = S_RUN;
                  quot_d  = '0;
                  rem_d   = '0;
                  dbz_d   = 1'b0;
               end
            end
         end

         S_RUN: begin
            q_d   = {q_q[size-2:0], no_borrow};
            r_d   = no_borrow ? diff : trial;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               quot_d  = q_d;
               rem_d   = r_d[size-1:0];
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         q_q     <= '0;
         d_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         d_q     <= d_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: doc/sayac_seq_divider.md
Name: sayac_seq_divider

Overview:
- Multi-cycle unsigned integer divider for the SAYAC datapath. Produces quotient and remainder.
- Is the inverse operation of the add/subtract unit: one trial subtraction per cycle, restoring algorithm.
- The subtraction is built from the existing adder_subtractor instance (subsel tied high), sized size+1.
- Sits beside the ALU; the controller stalls on busy and consumes results on done.

Parameters:
- size, 16, operand, quotient and remainder width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only in IDLE
- dividend  input  size  unsigned dividend; captured when start is accepted
- divisor  input  size  unsigned divisor; captured when start is accepted
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse; results valid
- quotient  output  size  unsigned quotient; held until the next accepted start
- remainder  output  size  unsigned remainder; held until the next accepted start
- div_by_zero  output  1  set with done when captured divisor == 0; held with the results

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - busy, done, div_by_zero, quotient and remainder all cleared.
  - Iteration counter and internal registers cleared.
  - A reset mid-operation aborts the division. No done is issued. Outputs read 0 after reset is released.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge captures dividend into Q, divisor into D, and clears R (size+1 bits) and the counter.
  - If divisor != 0 go to RUN; if divisor == 0 go to DONE.
  - quotient, remainder and div_by_zero are cleared at acceptance.
- RUN: each cycle performs one restoring step, MSB first.
  - Shift: T = {R[size-1:0], Q[size-1]}; Q = Q << 1.
  - Trial: S = T - {1'b0, D}, computed by adder_subtractor(size+1) with subsel=1. Its cout=1 means no borrow.
  - If cout=1: R = S and Q[0] = 1. Otherwise R = T and Q[0] = 0.
  - The counter increments each step. After exactly size steps, go to DONE.
- DONE (one cycle):
  - done = 1.
  - Normal case: quotient = Q and remainder = R[size-1:0].
  - Divide by zero: quotient = all ones, remainder = captured dividend, div_by_zero = 1.
  - Next state is always IDLE.
  - Result registers update on the edge entering DONE, so they are valid while done is high and stay stable afterwards.
- Timing, with start accepted at edge E:
  - Normal case: done is high in the cycle after edge E+size; the result is visible after size+1 edges.
  - Zero divisor: done is high in the cycle after edge E.
  - busy is high from edge E until the edge that leaves DONE.
- start while busy (RUN or DONE) is ignored; no queuing.
- start held high continuously: a new operation is accepted in the first IDLE cycle after DONE. Back-to-back throughput is size+2 cycles per division.
- Operand inputs may change freely after acceptance; only the captured copies are used.
- Edge cases:
  - Dividend < divisor gives quotient 0 and remainder = dividend.
  - Dividend = 0 gives 0/0 with div_by_zero low, provided divisor != 0.
- Arithmetic invariant: quotient*divisor + remainder == dividend, and remainder < divisor, for every divisor != 0.

Test Plan:
- (size=16) dividend=100, divisor=7, one start pulse -> done high in the cycle after edge E+16. quotient=14, remainder=2, div_by_zero=0. busy low after DONE.
- dividend=0xFFFF, divisor=1 -> quotient=0xFFFF, remainder=0. Repeat with divisor=0xFFFF -> quotient=1, remainder=0.
- dividend=5, divisor=0 -> done in the cycle after edge E. div_by_zero=1, quotient=0xFFFF, remainder=5. A following 9/3 -> div_by_zero=0, quotient=3, remainder=0.
- dividend=3, divisor=10 -> quotient=0, remainder=3. Pulse start again mid-RUN with 50/5 -> ignored; result stays 0/3 and only one done pulse occurs.
- Start 1000/3, pull rst low after 8 RUN cycles -> all outputs 0 immediately and no done pulse. After release, 1000/3 -> quotient=333, remainder=1.
- Random sweep, 2000 operand pairs with start held high -> every result satisfies the arithmetic invariant. Successive done pulses are spaced exactly size+2 cycles apart.
